// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the camera-link SPI master and slave.
// Holds the FSM state encoding, the default word width shared with the
// slave transmitter, and a small constant-evaluation helper.
package spi_pkg;

    // Default bits per transfer, shared with the slave transmitter.
    localparam int unsigned SPI_WORD_W = 32'd32;

    // SPI master FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } spi_state_e;

    // Larger of two unsigned values, used to size shared counters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with synchronous active-high reset.
// Used for miso and for any other single-bit asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_master_rx.sv
// spi_master_rx: SPI master receiver for the camera data link.
// Generates sclk (idle low, CLK_DIV high / CLK_DIV low), samples the
// synchronized miso at the end of each high phase, assembles a WORD_W-bit
// word MSB first and presents it with a one-cycle data_valid pulse. A GAP
// of GAP_CYCLES low cycles after each word lets the slave reload.
module spi_master_rx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 32'd8,
    parameter int unsigned WORD_W     = SPI_WORD_W,
    parameter int unsigned GAP_CYCLES = 32'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              miso,
    output logic              sclk,
    output logic              busy,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid
);

    localparam int unsigned BIT_W = $clog2(WORD_W) + 32'd1;
    localparam int unsigned DIV_W = $clog2(max_u(CLK_DIV, GAP_CYCLES));

    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] HIGH_LAST = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] LOW_LAST  = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(GAP_CYCLES - 32'd1);

    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(32'd1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 32'd1);
    localparam logic [BIT_W-1:0] BIT_COUNT = BIT_W'(WORD_W);

    spi_state_e        state_r;
    spi_state_e        state_nxt_s;
    logic [BIT_W-1:0]  bit_ctr_r;
    logic [BIT_W-1:0]  bit_ctr_nxt_s;
    logic [DIV_W-1:0]  div_ctr_r;
    logic [DIV_W-1:0]  div_ctr_nxt_s;
    logic [WORD_W-1:0] shift_r;
    logic [WORD_W-1:0] shift_nxt_s;
    logic              word_done_s;
    logic              miso_s;

    logic              sclk_r;
    logic              busy_r;
    logic [WORD_W-1:0] data_out_r;
    logic              data_valid_r;

    sync_2ff u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d   (miso),
        .q   (miso_s)
    );

    // Next-state logic: phase timing, bit sampling and word completion.
    always_comb begin
        state_nxt_s   = state_r;
        bit_ctr_nxt_s = bit_ctr_r;
        div_ctr_nxt_s = div_ctr_r;
        shift_nxt_s   = shift_r;
        word_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s   = HIGH;
                    bit_ctr_nxt_s = BIT_ZERO;
                    div_ctr_nxt_s = DIV_ZERO;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            HIGH: begin
                if (div_ctr_r == HIGH_LAST) begin
                    // End of high phase: this edge is the sampling edge.
                    state_nxt_s   = LOW;
                    div_ctr_nxt_s = DIV_ZERO;
                    shift_nxt_s   = {shift_r[WORD_W-2:0], miso_s};
                    bit_ctr_nxt_s = bit_ctr_r + BIT_ONE;
                    word_done_s   = (bit_ctr_r == BIT_LAST);
                end else begin
                    div_ctr_nxt_s = div_ctr_r + DIV_ONE;
                end
            end
            LOW: begin
                if (div_ctr_r == LOW_LAST) begin
                    div_ctr_nxt_s = DIV_ZERO;
                    if (bit_ctr_r < BIT_COUNT) begin
                        state_nxt_s = HIGH;
                    end else begin
                        state_nxt_s = GAP;
                    end
                end else begin
                    div_ctr_nxt_s = div_ctr_r + DIV_ONE;
                end
            end
            GAP: begin
                if (div_ctr_r == GAP_LAST) begin
                    state_nxt_s   = IDLE;
                    div_ctr_nxt_s = DIV_ZERO;
                end else begin
                    div_ctr_nxt_s = div_ctr_r + DIV_ONE;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                bit_ctr_nxt_s = BIT_ZERO;
                div_ctr_nxt_s = DIV_ZERO;
            end
        endcase
    end

    // FSM state, counters and shift register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_ctr_r <= BIT_ZERO;
            div_ctr_r <= DIV_ZERO;
            shift_r   <= {WORD_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            bit_ctr_r <= bit_ctr_nxt_s;
            div_ctr_r <= div_ctr_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Registered outputs, derived from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_r       <= 1'b0;
            busy_r       <= 1'b0;
            data_out_r   <= {WORD_W{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            sclk_r       <= (state_nxt_s == HIGH);
            busy_r       <= (state_nxt_s != IDLE);
            data_valid_r <= word_done_s;
            if (word_done_s) begin
                data_out_r <= shift_nxt_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign sclk       = sclk_r;
    assign busy       = busy_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;

endmodule

// File: tb/tb_spi_master_rx.sv
// tb_spi_master_rx: directed bench for spi_master_rx with behavioural slaves.
// DUT A uses the default parameters with a slave on the system clock; DUT B
// uses CLK_DIV=4, GAP_CYCLES=1 with a slave on an unrelated clock (period +6%).
module tb_spi_master_rx;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        sb_clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;
    logic        sclk_a, sclk_b;
    logic        busy_a, busy_b;
    logic [31:0] dout_a, dout_b;
    logic        dv_a, dv_b;

    // slave models
    logic        sa_rearm = 1'b0, sa_rearm_d = 1'b0, sa_sclk_d = 1'b0;
    logic        sb_rearm = 1'b0, sb_rearm_d = 1'b0, sb_sclk_d = 1'b0;
    logic [31:0] sa_sreg = 32'd0, sb_sreg = 32'd0;
    int          sa_cnt = 0, sb_cnt = 0;
    logic [31:0] sa_q[$];
    logic [31:0] sb_q[$];

    // scoreboard and monitor state
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          cyc;
    int          run_len;
    logic        sclk_prev;
    int          pw_a;
    int          pulses_a;
    int          word_rise_cyc;
    int          word_gap_len;
    int          nv_a;
    int          nv_b;
    int          n_assert;
    int          n_fail;

    spi_master_rx #(.CLK_DIV(32'd8), .WORD_W(32'd32), .GAP_CYCLES(32'd16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .miso(miso_a),
        .sclk(sclk_a), .busy(busy_a), .data_out(dout_a), .data_valid(dv_a)
    );

    spi_master_rx #(.CLK_DIV(32'd4), .WORD_W(32'd32), .GAP_CYCLES(32'd1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .miso(miso_b),
        .sclk(sclk_b), .busy(busy_b), .data_out(dout_b), .data_valid(dv_b)
    );

    always #50 clk = ~clk;
    always #53 sb_clk = ~sb_clk;

    // Slave A: new bit after each rising sclk, reload after the 32nd falling edge.
    always @(posedge clk) begin
        sa_sclk_d  <= sclk_a;
        sa_rearm_d <= sa_rearm;
        if (sa_rearm && !sa_rearm_d) begin
            if (sa_q.size() > 0) sa_sreg <= sa_q.pop_front();
            else sa_sreg <= 32'd0;
            sa_cnt <= 0;
        end else if (sclk_a && !sa_sclk_d) begin
            miso_a  <= sa_sreg[31];
            sa_sreg <= {sa_sreg[30:0], 1'b0};
            sa_cnt  <= sa_cnt + 1;
        end else if (!sclk_a && sa_sclk_d && sa_cnt == 32) begin
            if (sa_q.size() > 0) sa_sreg <= sa_q.pop_front();
            else sa_sreg <= 32'd0;
            sa_cnt <= 0;
        end
    end

    // Slave B: same behaviour, clocked by its own unrelated clock.
    always @(posedge sb_clk) begin
        sb_sclk_d  <= sclk_b;
        sb_rearm_d <= sb_rearm;
        if (sb_rearm && !sb_rearm_d) begin
            if (sb_q.size() > 0) sb_sreg <= sb_q.pop_front();
            else sb_sreg <= 32'd0;
            sb_cnt <= 0;
        end else if (sclk_b && !sb_sclk_d) begin
            miso_b  <= sb_sreg[31];
            sb_sreg <= {sb_sreg[30:0], 1'b0};
            sb_cnt  <= sb_cnt + 1;
        end else if (!sclk_b && sb_sclk_d && sb_cnt == 32) begin
            if (sb_q.size() > 0) sb_sreg <= sb_q.pop_front();
            else sb_sreg <= 32'd0;
            sb_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle, sample at the falling edge, track sclk shape and scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc = cyc + 1;
        if (sclk_a !== sclk_prev) begin
            if (sclk_prev === 1'b1) begin
                check("sclk_high_len", 32'(run_len), 32'd8);
                pw_a = pw_a + 1;
                if (pw_a == 32) pw_a = 0;
            end else begin
                if (pw_a != 0) begin
                    check("sclk_low_len", 32'(run_len), 32'd8);
                end else begin
                    word_rise_cyc = cyc;
                    word_gap_len  = run_len;
                end
                pulses_a++;
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        sclk_prev = sclk_a;
        if (dv_a === 1'b1) begin
            nv_a++;
            check("dv_a_expected", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("data_a", dout_a, e.word);
                if (e.cyc != 0) check("dv_a_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (dv_b === 1'b1) begin
            nv_b++;
            check("dv_b_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("data_b", dout_b, e.word);
            end
        end
    endtask

    task automatic push_exp_a(input logic [31:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc  = c;
        q_a.push_back(e);
    endtask

    // Load slave A with a word and start one transfer during the returned cycle k.
    task automatic start_word_a(input logic [31:0] w, input logic expect_it, output int k);
        sa_q.push_back(w);
        sa_rearm = 1'b1;
        step();
        sa_rearm = 1'b0;
        step();
        start_a = 1'b1;
        k = cyc;
        if (expect_it) push_exp_a(w, k + 505);
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_a !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        check("idle_reached", 32'(busy_a), 32'd0);
    endtask

    initial begin
        int k;
        int p0;
        int v0;
        int n;
        logic [31:0] w;
        exp_t e;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        cyc = 1; run_len = 0; sclk_prev = 1'b0; pw_a = 0; pulses_a = 0;
        word_rise_cyc = 0; word_gap_len = 0; nv_a = 0; nv_b = 0;
        n_assert = 0; n_fail = 0;

        // Reset state
        repeat (3) step();
        check("rst_sclk_a", 32'(sclk_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_dv_a", 32'(dv_a), 32'd0);
        check("rst_dout_a", dout_a, 32'd0);
        check("rst_sclk_b", 32'(sclk_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_dout_b", dout_b, 32'd0);
        rst = 1'b0;

        // Single word, start during cycle 10: valid at 515, busy 11..538
        while (cyc < 8) step();
        p0 = pulses_a; v0 = nv_a;
        start_word_a(32'hA5C3_0F01, 1'b1, k);
        while (cyc <= k + 535) begin
            check("t1_busy", 32'(busy_a), 32'((cyc >= k + 1) && (cyc <= k + 528)));
            step();
        end
        check("t1_pulses", 32'(pulses_a - p0), 32'd32);
        check("t1_valids", 32'(nv_a - v0), 32'd1);
        check("t1_sb_empty", 32'(q_a.size()), 32'd0);

        // Back-to-back with start held high
        sa_q.push_back(32'hFFFF_FFFF);
        sa_q.push_back(32'h0000_0000);
        sa_rearm = 1'b1; step(); sa_rearm = 1'b0; step();
        start_a = 1'b1;
        k = cyc;
        push_exp_a(32'hFFFF_FFFF, k + 505);
        push_exp_a(32'h0000_0000, k + 529 + 505);
        n = 0;
        while (q_a.size() > 0 && n < 1300) begin
            step();
            n++;
            if (cyc >= k + 531) start_a = 1'b0;
        end
        start_a = 1'b0;
        check("t2_words_done", 32'(q_a.size()), 32'd0);
        check("t2_second_start", 32'(word_rise_cyc), 32'(k + 530));
        check("t2_gap_low_len", 32'(word_gap_len), 32'd25);
        wait_idle(100);

        // start pulsed during bit 5 is ignored
        p0 = pulses_a; v0 = nv_a;
        start_word_a(32'h5A5A_3C3C, 1'b1, k);
        while (cyc < k + 83) step();
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_idle(700);
        repeat (40) step();
        check("t3_pulses", 32'(pulses_a - p0), 32'd32);
        check("t3_valids", 32'(nv_a - v0), 32'd1);
        check("t3_busy_end", 32'(busy_a), 32'd0);

        // Reset after the 12th pulse aborts the word
        v0 = nv_a;
        start_word_a(32'hDEAD_BEEF, 1'b0, k);
        n = 0;
        while (pw_a != 12 && n < 400) begin step(); n++; end
        check("t4_reach_pulse12", 32'(pw_a), 32'd12);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("t4_sclk", 32'(sclk_a), 32'd0);
        check("t4_busy", 32'(busy_a), 32'd0);
        check("t4_dout", dout_a, 32'd0);
        check("t4_dv", 32'(dv_a), 32'd0);
        pw_a = 0;
        p0 = pulses_a;
        repeat (600) step();
        check("t4_no_valid", 32'(nv_a - v0), 32'd0);
        check("t4_quiet_pulses", 32'(pulses_a - p0), 32'd0);
        start_word_a(32'h1234_5678, 1'b1, k);
        wait_idle(700);
        check("t4_fresh_valid", 32'(nv_a - v0), 32'd1);
        check("t4_sb_empty", 32'(q_a.size()), 32'd0);

        // start and rst together from IDLE
        p0 = pulses_a;
        rst = 1'b1; start_a = 1'b1; step(); rst = 1'b0; start_a = 1'b0;
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_sclk", 32'(sclk_a), 32'd0);
        repeat (20) step();
        check("t5_busy_later", 32'(busy_a), 32'd0);
        check("t5_no_pulses", 32'(pulses_a - p0), 32'd0);

        // DUT B: 100 random words, slave on an unrelated clock
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            sb_q.push_back(w);
            e.word = w;
            e.cyc  = 0;
            q_b.push_back(e);
        end
        sb_rearm = 1'b1; repeat (3) step(); sb_rearm = 1'b0; step();
        v0 = nv_b;
        start_b = 1'b1;
        n = 0;
        while ((nv_b - v0) < 100 && n < 32000) begin step(); n++; end
        start_b = 1'b0;
        check("t6_valid_count", 32'(nv_b - v0), 32'd100);
        check("t6_sb_empty", 32'(q_b.size()), 32'd0);
        repeat (20) step();
        check("t6_busy_end", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
